// File: rtl/coresub_sramtrm_loader.sv
// coresub_sramtrm_loader: APB initiator that replays a table of up to N
// (address, data) writes, e.g. SRAM trim CSRs from fuse shadow values.
// Reports done/err status with the failing table index.
// Optional feature: define SRAMTRM_LDR_VERIFY_EN to read back every
// successful write and compare the returned data.
module coresub_sramtrm_loader #(
  parameter int N   = 8,
  parameter int AW  = 12,
  parameter int DW  = 32,
  parameter int TOW = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [N-1:0]    cfgvld,
  input  logic [N*AW-1:0] cfgaddr,
  input  logic [N*DW-1:0] cfgdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      errcode,
  output logic [3:0]      erridx,
  output logic            apbm_psel,
  output logic            apbm_penable,
  output logic            apbm_pwrite,
  output logic [AW-1:0]   apbm_paddr,
  output logic [DW-1:0]   apbm_pwdata,
  input  logic [DW-1:0]   apbm_prdata,
  input  logic            apbm_pready,
  input  logic            apbm_pslverr
);

  // idx must be able to hold N itself (up to 16)
  localparam int IW = 5;
  // Last ACCESS cycle before abort: the (2**TOW-1)th cycle sees count 2**TOW-2
  localparam logic [TOW-1:0] TMO_LAST = {{(TOW-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE, SCAN, WSETUP, WACCESS,
`ifdef SRAMTRM_LDR_VERIFY_EN
    RSETUP, RACCESS,
`endif
    DONE, ERR
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [TOW-1:0]  tmo_q;
  logic            psel_q, penable_q, pwrite_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;
  logic            busy_q, done_q, err_q;
  logic [1:0]      errcode_q;
  logic [3:0]      erridx_q;

  logic            cur_vld;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_data;
  logic            last_ent, idx_end, in_acc;
  logic [1:0]      fail_code;

  // Select the table entry addressed by idx (mux avoids oversized bit-select index)
  always_comb begin
    cur_vld  = 1'b0;
    cur_addr = '0;
    cur_data = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        cur_vld  = cfgvld[i];
        cur_addr = cfgaddr[i*AW +: AW];
        cur_data = cfgdata[i*DW +: DW];
      end
    end
  end

  assign last_ent = (idx_q == IW'(N-1));
  assign idx_end  = (idx_q >= IW'(N));
`ifdef SRAMTRM_LDR_VERIFY_EN
  assign in_acc   = (state_q == WACCESS) || (state_q == RACCESS);
`else
  assign in_acc   = (state_q == WACCESS);
`endif

  // Classify the current ACCESS cycle: pslverr, readback mismatch, or timeout.
  // pready in the saturating cycle completes normally, so timeout needs !pready.
  always_comb begin
    fail_code = 2'b00;
    if (in_acc) begin
      if (apbm_pready) begin
        if (apbm_pslverr) fail_code = 2'b01;
`ifdef SRAMTRM_LDR_VERIFY_EN
        else if (state_q == RACCESS && apbm_prdata != pwdata_q) fail_code = 2'b11;
`endif
      end else if (tmo_q == TMO_LAST) begin
        fail_code = 2'b10;
      end
    end
  end

  // Replay FSM; all bus and status outputs are registered here.
  // Finishing the last entry goes straight to DONE, so an all-invalid table
  // costs exactly N SCAN cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tmo_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      errcode_q <= 2'b00;
      erridx_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            errcode_q <= 2'b00;
            erridx_q  <= 4'd0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (idx_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (cur_vld) begin
            paddr_q   <= cur_addr;
            pwdata_q  <= cur_data;
            pwrite_q  <= 1'b1;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= WSETUP;
          end else if (last_ent) begin
            idx_q   <= idx_q + IW'(1);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        WSETUP: begin
          penable_q <= 1'b1;
          tmo_q     <= '0;
          state_q   <= WACCESS;
        end
`ifdef SRAMTRM_LDR_VERIFY_EN
        RSETUP: begin
          penable_q <= 1'b1;
          tmo_q     <= '0;
          state_q   <= RACCESS;
        end
        WACCESS, RACCESS: begin
`else
        WACCESS: begin
`endif
          if (fail_code != 2'b00) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b1;
            errcode_q <= fail_code;
            erridx_q  <= idx_q[3:0];
            state_q   <= ERR;
          end else if (apbm_pready) begin
            penable_q <= 1'b0;
`ifdef SRAMTRM_LDR_VERIFY_EN
            if (state_q == WACCESS) begin
              // keep psel high: the readback setup phase follows directly
              pwrite_q <= 1'b0;
              state_q  <= RSETUP;
            end else
`endif
            begin
              psel_q <= 1'b0;
              idx_q  <= idx_q + IW'(1);
              if (last_ent) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                state_q <= SCAN;
              end
            end
          end else begin
            tmo_q <= tmo_q + TOW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign errcode      = errcode_q;
  assign erridx       = erridx_q;
  assign apbm_psel    = psel_q;
  assign apbm_penable = penable_q;
  assign apbm_pwrite  = pwrite_q;
  assign apbm_paddr   = paddr_q;
  assign apbm_pwdata  = pwdata_q;

endmodule
